prio_event_encoder: RTL and testbench

PRIO_EVENT_ENCODER -- requirements
Module: prio_event_encoder

---
 rtl/prio_event_encoder_pkg.sv | 17 +
 rtl/prio_event_encoder_if.sv | 29 ++
 rtl/prio_event_encoder_pick.sv | 35 +++
 rtl/prio_event_encoder.sv | 60 ++++++
 tb/tb_prio_event_encoder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_event_encoder_pkg.sv
// Shared definitions for the priority event encoder: selection-order
// constants and the index-width helper.
package prio_pkg;

    // Selection order: which end of the request vector wins.
    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    // Bits needed to encode an index in 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_event_encoder_if.sv
// Request/grant bundle between a producer/consumer (master) and the
// encoder (slave).
interface prio_event_encoder_if #(
    parameter int N = 8
) ();
    import prio_pkg::*;

    localparam int W = clog2(N);

    logic         en;
    logic [N-1:0] din;
    logic [N-1:0] mask;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic [N-1:0] pending;
    logic         overflow;

    modport master (
        output en, din, mask, out_ready,
        input  out_valid, y, pending, overflow
    );

    modport slave (
        input  en, din, mask, out_ready,
        output out_valid, y, pending, overflow
    );

endinterface

// File: rtl/prio_event_encoder_pick.sv
// Combinational priority picker: returns the index of the winning set bit
// of req (highest or lowest, by MSB_FIRST) and whether any bit was set.
module prio_pick #(
    parameter  int N         = 8,
    parameter  int MSB_FIRST = prio_pkg::MSB_FIRST,
    localparam int W         = prio_pkg::clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan toward the winning end so the last hit in the loop is the winner.
    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        idx   = '0;
        found = 1'b0;
        if (MSB_FIRST != prio_pkg::LSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prio_event_encoder.sv
// Priority event encoder: accumulates sampled request pulses into a pending
// vector and grants one eligible channel per load through a registered
// valid/ready output stage.
module prio_event_encoder #(
    parameter int N         = 8,
    parameter int MSB_FIRST = prio_pkg::MSB_FIRST
) (
    input logic                 clk,
    input logic                 rst,
    prio_event_encoder_if.slave bus
);
    import prio_pkg::*;

    localparam int W = clog2(N);

    logic [N-1:0] eligible;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic [W-1:0] win_idx;
    logic         win_found;
    logic         load;

    // Winner is taken from registered state only, never from din.
    assign eligible = bus.pending & ~bus.mask;

    prio_pick #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .req   (eligible),
        .idx   (win_idx),
        .found (win_found)
    );

    // Output stage is free when empty or being accepted this cycle.
    assign load    = !bus.out_valid || bus.out_ready;
    assign set_vec = bus.en ? bus.din : '0;
    assign clr_vec = (load && win_found) ? (N'(1) << win_idx) : '0;

    // Pending/grant/overflow state; a set on the clearing edge wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pending   <= '0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            bus.pending  <= (bus.pending & ~clr_vec) | set_vec;
            bus.overflow <= |(set_vec & bus.pending & ~clr_vec);
            if (load) begin
                bus.out_valid <= win_found;
                if (win_found) begin
                    bus.y <= win_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Self-checking bench: an N=8 MSB-first encoder and an N=5 LSB-first encoder
// run against a behavioural model, with directed scenarios and random traffic.
module tb_prio_event_encoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prio_event_encoder_if #(.N(8)) ia ();
    prio_event_encoder_if #(.N(5)) ib ();

    prio_event_encoder #(.N(8), .MSB_FIRST(prio_pkg::MSB_FIRST)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    prio_event_encoder #(.N(5), .MSB_FIRST(prio_pkg::LSB_FIRST)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pending bits as a plain array, winner found by search.
    int m_n[2]   = '{8, 5};
    bit m_msb[2] = '{1'b1, 1'b0};
    bit m_pend[2][8];
    bit m_valid[2];
    int m_y[2];
    bit m_ovf[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
            m_valid[d] = 1'b0;
            m_y[d]     = 0;
            m_ovf[d]   = 1'b0;
        end
    endtask

    function automatic logic [63:0] pend_vec(input int d);
        logic [63:0] v = '0;
        for (int i = 0; i < m_n[d]; i++) v[i] = m_pend[d][i];
        return v;
    endfunction

    task automatic model_step(input int d, input bit en, input logic [7:0] din,
                              input logic [7:0] mask, input bit rdy);
        bit load = !m_valid[d] || rdy;
        int win  = -1;
        int clr  = -1;
        for (int i = 0; i < m_n[d]; i++)
            if (m_pend[d][i] && !mask[i] && (win < 0 || m_msb[d])) win = i;
        if (load && win >= 0) clr = win;
        m_ovf[d] = 1'b0;
        for (int i = 0; i < m_n[d]; i++) begin
            if (en && din[i]) begin
                if (m_pend[d][i] && i != clr) m_ovf[d] = 1'b1;
                m_pend[d][i] = 1'b1;
            end else if (i == clr) begin
                m_pend[d][i] = 1'b0;
            end
        end
        if (load) begin
            m_valid[d] = (win >= 0);
            if (win >= 0) m_y[d] = win;
        end
    endtask

    task automatic compare_all();
        check("a_valid",    64'(ia.out_valid), 64'(m_valid[0]));
        check("a_pending",  64'(ia.pending),   pend_vec(0));
        check("a_overflow", 64'(ia.overflow),  64'(m_ovf[0]));
        if (m_valid[0]) check("a_y", 64'(ia.y), 64'(m_y[0]));
        check("b_valid",    64'(ib.out_valid), 64'(m_valid[1]));
        check("b_pending",  64'(ib.pending),   pend_vec(1));
        check("b_overflow", 64'(ib.overflow),  64'(m_ovf[1]));
        if (m_valid[1]) check("b_y", 64'(ib.y), 64'(m_y[1]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_step(0, ia.en, ia.din, ia.mask, ia.out_ready);
            model_step(1, ib.en, 8'(ib.din), 8'(ib.mask), ib.out_ready);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_a(input bit en, input logic [7:0] din, input logic [7:0] mask, input bit rdy);
        ia.en = en; ia.din = din; ia.mask = mask; ia.out_ready = rdy;
    endtask

    task automatic drive_b(input bit en, input logic [4:0] din, input logic [4:0] mask, input bit rdy);
        ib.en = en; ib.din = din; ib.mask = mask; ib.out_ready = rdy;
    endtask

    int ovf_count;

    initial begin
        // Reset with all requests asserted.
        rst = 1'b1;
        model_reset();
        drive_a(1'b1, 8'hFF, 8'h00, 1'b1);
        drive_b(1'b0, 5'h00, 5'h00, 1'b1);
        #1;
        check("rst_pending",  64'(ia.pending),   64'h0);
        check("rst_valid",    64'(ia.out_valid), 64'h0);
        check("rst_y",        64'(ia.y),         64'h0);
        check("rst_overflow", 64'(ia.overflow),  64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_first_pending", 64'(ia.pending), 64'hFF);
        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        check("rst_first_y",     64'(ia.y),         64'd7);
        check("rst_first_valid", 64'(ia.out_valid), 64'd1);
        for (int i = 6; i >= 0; i--) begin
            tick();
            check("rst_drain_y", 64'(ia.y), 64'(i));
        end
        tick();
        check("rst_drain_idle", 64'(ia.out_valid), 64'd0);

        // Drain order from a single-cycle pattern.
        drive_a(1'b1, 8'b1010_0101, 8'h00, 1'b1);
        tick();
        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        tick(); check("drain_y0", 64'(ia.y), 64'd7);
        tick(); check("drain_y1", 64'(ia.y), 64'd5);
        tick(); check("drain_y2", 64'(ia.y), 64'd2);
        tick(); check("drain_y3", 64'(ia.y), 64'd0);
        tick();
        check("drain_valid",   64'(ia.out_valid), 64'd0);
        check("drain_pending", 64'(ia.pending),   64'h0);

        // Backpressure on a presented grant while bit 7 is re-requested.
        drive_a(1'b1, 8'h80, 8'h00, 1'b0);
        tick();
        tick();
        check("bp_y_first",   64'(ia.y),         64'd7);
        check("bp_collision", 64'(ia.overflow),  64'd0);
        ovf_count = 0;
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, (k == 1) ? 8'h80 : 8'h00, 8'h00, 1'b0);
            tick();
            check("bp_hold_y",     64'(ia.y),         64'd7);
            check("bp_hold_valid", 64'(ia.out_valid), 64'd1);
            ovf_count += int'(ia.overflow);
        end
        check("bp_overflow_count", 64'(ovf_count), 64'd1);
        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        check("bp_regrant_y",     64'(ia.y),         64'd7);
        check("bp_regrant_valid", 64'(ia.out_valid), 64'd1);
        tick();
        check("bp_idle", 64'(ia.out_valid), 64'd0);

        // Masked channel retained, granted once unmasked.
        drive_a(1'b1, 8'b0000_1001, 8'b0000_1000, 1'b1);
        tick();
        drive_a(1'b0, 8'h00, 8'b0000_1000, 1'b1);
        tick();
        check("mask_y",       64'(ia.y),       64'd0);
        check("mask_pending", 64'(ia.pending), 64'h08);
        tick();
        check("mask_blocked", 64'(ia.out_valid), 64'd0);
        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        check("mask_cleared_y",     64'(ia.y),         64'd3);
        check("mask_cleared_valid", 64'(ia.out_valid), 64'd1);
        tick();

        // Set/clear collision with a held request.
        drive_a(1'b1, 8'h10, 8'h00, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("coll_y",        64'(ia.y),         64'd4);
            check("coll_valid",    64'(ia.out_valid), 64'd1);
            check("coll_overflow", 64'(ia.overflow),  64'd0);
        end
        drive_a(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        tick();
        check("coll_idle", 64'(ia.out_valid), 64'd0);

        // Five-channel LSB-first instance, reset in the middle of the drain.
        drive_b(1'b1, 5'b10110, 5'h00, 1'b1);
        tick();
        drive_b(1'b0, 5'h00, 5'h00, 1'b1);
        tick(); check("b_seq_y0", 64'(ib.y), 64'd1);
        tick(); check("b_seq_y1", 64'(ib.y), 64'd2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("b_rst_pending", 64'(ib.pending),   64'h0);
        check("b_rst_valid",   64'(ib.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b_after_rst_valid", 64'(ib.out_valid), 64'd0);
        end

        // Random traffic on both instances, with occasional reset.
        for (int c = 0; c < 800; c++) begin
            drive_a($urandom_range(0, 3) != 0, 8'($urandom & $urandom & $urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                    $urandom_range(0, 3) != 0);
            drive_b($urandom_range(0, 3) != 0, 5'($urandom & $urandom),
                    ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00,
                    $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
